// File: rtl/pattern_game_ctrl_pkg.sv
// Shared types and constants for the key-pattern game sequencer.
// State encoding, register map, CTRL/STATUS bit positions, DONE LED codes.
package pattern_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHOW_ON  = 3'd1,
        ST_SHOW_GAP = 3'd2,
        ST_INPUT    = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam logic [1:0] ADDR_PATTERN    = 2'd0;
    localparam logic [1:0] ADDR_CTRL       = 2'd1;
    localparam logic [1:0] ADDR_STEP_TICKS = 2'd2;
    localparam logic [1:0] ADDR_SCORE      = 2'd3;

    localparam int CTRL_START_BIT = 8;
    localparam int CTRL_ACK_BIT   = 9;
    localparam int CTRL_CLR_BIT   = 10;

    localparam int STAT_PASS_BIT  = 8;
    localparam int STAT_FAIL_BIT  = 9;
    localparam int STAT_ABORT_BIT = 10;
    localparam int STAT_BUSY_BIT  = 11;

    localparam logic [7:0] LED_PASS  = 8'hFF;
    localparam logic [7:0] LED_FAIL  = 8'h0F;
    localparam logic [7:0] LED_ABORT = 8'hF0;

    function automatic logic [3:0] sym_onehot(input logic [1:0] s);
        sym_onehot = 4'b0001 << s;
    endfunction

    // Round length is kept in 1..8
    function automatic logic [3:0] clamp_len(input logic [3:0] v);
        if (v == 4'd0)
            clamp_len = 4'd1;
        else if (v > 4'd8)
            clamp_len = 4'd8;
        else
            clamp_len = v;
    endfunction

endpackage

// File: rtl/pattern_game_ctrl_key_debounce.sv
// Key conditioner: 2-flop synchronizer, stability counter, press pulse.
// A press is a one-cycle pulse on an accepted high-to-low level change.
module pattern_game_ctrl_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count how long the synchronized level has differed from the accepted one
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Idle key level is high (released)
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/pattern_game_ctrl.sv
// Key-pattern game sequencer: shows a symbol pattern on the LEDs,
// scores debounced key entries against it and flags the result by irq.
module pattern_game_ctrl
    import pattern_game_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [1:0]  key,
    input  logic [3:0]  switch,
    output logic [7:0]  led,
    output logic        irq
);

    logic press_enter;
    logic press_abort;

    pattern_game_ctrl_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_enter (
        .clk   (clk),
        .reset (reset),
        .key_n (key[0]),
        .press (press_enter)
    );

    pattern_game_ctrl_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_abort (
        .clk   (clk),
        .reset (reset),
        .key_n (key[1]),
        .press (press_abort)
    );

    logic unused_inputs;
    assign unused_inputs = ^{writedata[31:24], switch[3:2]};

    state_e      state_q, state_d;
    logic [1:0]  sw1_q, sw1_d;
    logic [1:0]  sw2_q, sw2_d;
    logic [15:0] pattern_q, pattern_d;
    logic [3:0]  len_q, len_d;
    logic [23:0] step_ticks_q, step_ticks_d;
    logic [7:0]  score_q, score_d;
    logic [3:0]  idx_q, idx_d;
    logic [23:0] tick_cnt_q, tick_cnt_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        abort_q, abort_d;
    logic        irq_q, irq_d;
    logic [7:0]  led_q, led_d;
    logic [31:0] readdata_q, readdata_d;

    logic        busy;
    logic        wr_ctrl;
    logic        start_req;
    logic        tick_done;
    logic        last_step;
    logic [23:0] ticks_eff;
    logic [1:0]  cur_sym;

    // Register writes, round sequencing, scoring and display selection
    always_comb begin
        state_d      = state_q;
        sw1_d        = switch[1:0];
        sw2_d        = sw1_q;
        pattern_d    = pattern_q;
        len_d        = len_q;
        step_ticks_d = step_ticks_q;
        score_d      = score_q;
        idx_d        = idx_q;
        tick_cnt_d   = tick_cnt_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        abort_d      = abort_q;
        irq_d        = irq_q;
        led_d        = 8'h00;
        readdata_d   = 32'h0;

        busy = (state_q == ST_SHOW_ON) ||
               (state_q == ST_SHOW_GAP) ||
               (state_q == ST_INPUT);
        wr_ctrl   = write && (address == ADDR_CTRL);
        start_req = wr_ctrl && writedata[CTRL_START_BIT];
        ticks_eff = (step_ticks_q == 24'd0) ? 24'd1 : step_ticks_q;
        tick_done = (tick_cnt_q == ticks_eff - 24'd1);
        last_step = (idx_q == len_q - 4'd1);
        cur_sym   = pattern_q[{idx_q[2:0], 1'b0} +: 2];

        if (write && address == ADDR_STEP_TICKS)
            step_ticks_d = writedata[23:0];
        if (write && address == ADDR_PATTERN && !busy)
            pattern_d = writedata[15:0];
        if (wr_ctrl && writedata[CTRL_ACK_BIT])
            irq_d = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_req) begin
                    state_d    = ST_SHOW_ON;
                    idx_d      = 4'd0;
                    tick_cnt_d = 24'd0;
                    len_d      = clamp_len(writedata[3:0]);
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                    abort_d    = 1'b0;
                    irq_d      = 1'b0;
                end
            end
            ST_SHOW_ON: begin
                if (press_abort) begin
                    state_d = ST_DONE;
                    abort_d = 1'b1;
                    irq_d   = 1'b1;
                end else if (tick_done) begin
                    state_d    = ST_SHOW_GAP;
                    tick_cnt_d = 24'd0;
                end else begin
                    tick_cnt_d = tick_cnt_q + 24'd1;
                end
            end
            ST_SHOW_GAP: begin
                if (press_abort) begin
                    state_d = ST_DONE;
                    abort_d = 1'b1;
                    irq_d   = 1'b1;
                end else if (tick_done) begin
                    tick_cnt_d = 24'd0;
                    if (last_step) begin
                        state_d = ST_INPUT;
                        idx_d   = 4'd0;
                    end else begin
                        state_d = ST_SHOW_ON;
                        idx_d   = idx_q + 4'd1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + 24'd1;
                end
            end
            ST_INPUT: begin
                if (press_abort) begin
                    state_d = ST_DONE;
                    abort_d = 1'b1;
                    irq_d   = 1'b1;
                end else if (press_enter) begin
                    if (sw2_q != cur_sym) begin
                        state_d = ST_DONE;
                        fail_d  = 1'b1;
                        irq_d   = 1'b1;
                    end else if (last_step) begin
                        state_d = ST_DONE;
                        pass_d  = 1'b1;
                        irq_d   = 1'b1;
                        if (score_q != 8'hFF)
                            score_d = score_q + 8'd1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_ctrl && writedata[CTRL_CLR_BIT])
            score_d = 8'd0;

        unique case (state_d)
            ST_SHOW_ON:
                led_d = {1'b1, idx_d[2:0],
                         sym_onehot(pattern_d[{idx_d[2:0], 1'b0} +: 2])};
            ST_INPUT:
                led_d = {4'b0000, sym_onehot(sw2_q)};
            ST_DONE: begin
                unique case (1'b1)
                    pass_d:  led_d = LED_PASS;
                    fail_d:  led_d = LED_FAIL;
                    abort_d: led_d = LED_ABORT;
                    default: led_d = 8'h00;
                endcase
            end
            default: led_d = 8'h00;
        endcase

        if (read) begin
            unique case (address)
                ADDR_PATTERN:    readdata_d = {16'h0, pattern_q};
                ADDR_CTRL:       readdata_d = {20'h0, busy, abort_q,
                                               fail_q, pass_q, idx_q,
                                               1'b0, state_q};
                ADDR_STEP_TICKS: readdata_d = {8'h0, step_ticks_q};
                ADDR_SCORE:      readdata_d = {24'h0, score_q};
                default:         readdata_d = 32'h0;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sw1_q        <= 2'b00;
            sw2_q        <= 2'b00;
            pattern_q    <= 16'h0;
            len_q        <= 4'd1;
            step_ticks_q <= 24'd1;
            score_q      <= 8'd0;
            idx_q        <= 4'd0;
            tick_cnt_q   <= 24'd0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            abort_q      <= 1'b0;
            irq_q        <= 1'b0;
            led_q        <= 8'h00;
            readdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            sw1_q        <= sw1_d;
            sw2_q        <= sw2_d;
            pattern_q    <= pattern_d;
            len_q        <= len_d;
            step_ticks_q <= step_ticks_d;
            score_q      <= score_d;
            idx_q        <= idx_d;
            tick_cnt_q   <= tick_cnt_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            abort_q      <= abort_d;
            irq_q        <= irq_d;
            led_q        <= led_d;
            readdata_q   <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign led      = led_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pattern_game_ctrl.sv
// Directed bench for pattern_game_ctrl: register table, show sequence,
// pass/fail/abort rounds, bounce rejection and mid-round reset.
module tb_pattern_game_ctrl;

    localparam int DB = 8;
    localparam int PRESS_WAIT = DB + 8;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        write;
    logic [31:0] writedata;
    logic [1:0]  key;
    logic [3:0]  switch;
    logic [7:0]  led;
    logic        irq;

    int checks = 0;
    int errors = 0;

    pattern_game_ctrl #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .readdata  (readdata),
        .write     (write),
        .writedata (writedata),
        .key       (key),
        .switch    (switch),
        .led       (led),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[$];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
        writedata = 32'h0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d    = readdata;
    endtask

    task automatic press(input int which, input logic [1:0] sym);
        switch[1:0] = sym;
        tick(3);
        key[which] = 1'b0;
        tick(PRESS_WAIT);
        key[which] = 1'b1;
        tick(PRESS_WAIT);
    endtask

    task automatic wait_led(input logic [7:0] exp, input int budget,
                            input string nm);
        int n;
        n = 0;
        while (led !== exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {24'h0, led}, {24'h0, exp});
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  shown [4];
        logic [7:0]  exp_led;

        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  shown [4];
        logic [7:0]  exp_led;

        shown[0] = 8'h81;
        shown[1] = 8'h92;
        shown[2] = 8'hA4;
        shown[3] = 8'hB8;

        vt.push_back('{1'b0, 2'd0, 32'h0, 32'h0, "rst_pattern"});
        vt.push_back('{1'b0, 2'd1, 32'h0, 32'h0, "rst_status"});
        vt.push_back('{1'b0, 2'd2, 32'h0, 32'h1, "rst_step"});
        vt.push_back('{1'b0, 2'd3, 32'h0, 32'h0, "rst_score"});
        vt.push_back('{1'b1, 2'd0, 32'hABCD1234, 32'h0, "wr_pat"});
        vt.push_back('{1'b0, 2'd0, 32'h0, 32'h1234, "pat_mask"});
        vt.push_back('{1'b1, 2'd2, 32'hFF123456, 32'h0, "wr_step"});
        vt.push_back('{1'b0, 2'd2, 32'h0, 32'h123456, "step_mask"});
        vt.push_back('{1'b1, 2'd1, 32'h400, 32'h0, "wr_clr"});
        vt.push_back('{1'b0, 2'd1, 32'h0, 32'h0, "clr_no_start"});
        vt.push_back('{1'b1, 2'd2, 32'h0, 32'h0, "wr_step0"});
        vt.push_back('{1'b0, 2'd2, 32'h0, 32'h0, "step0_rd"});
        vt.push_back('{1'b1, 2'd0, 32'hE4, 32'h0, "wr_pat_e4"});
        vt.push_back('{1'b0, 2'd0, 32'h0, 32'hE4, "pat_e4"});
        vt.push_back('{1'b1, 2'd2, 32'h3, 32'h0, "wr_step3"});
        vt.push_back('{1'b0, 2'd2, 32'h0, 32'h3, "step3"});

        reset     = 1'b1;
        address   = 2'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = 32'h0;
        key       = 2'b11;
        switch    = 4'h0;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_led", {24'h0, led}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].wr) begin
                bus_wr(vt[i].addr, vt[i].data);
            end else begin
                bus_rd(vt[i].addr, rd);
                chk(vt[i].name, rd, vt[i].exp);
            end
        end

        // show sequence: length 4, 3-cycle phases
        bus_wr(2'd1, 32'h104);
        for (int k = 0; k < 24; k++) begin
            exp_led = ((k % 6) < 3) ? shown[k / 6] : 8'h00;
            chk($sformatf("show_%0d", k), {24'h0, led}, {24'h0, exp_led});
            @(negedge clk);
        end
        chk("input_led", {24'h0, led}, 32'h01);
        bus_rd(2'd1, rd);
        chk("input_status", rd, 32'h803);

        // pass round
        press(0, 2'd0);
        bus_rd(2'd1, rd);
        chk("step1_status", rd, 32'h813);
        press(0, 2'd1);
        press(0, 2'd2);
        press(0, 2'd3);
        chk("pass_led", {24'h0, led}, 32'hFF);
        chk("pass_irq", {31'h0, irq}, 32'h1);
        bus_rd(2'd1, rd);
        chk("pass_status", rd & 32'hF0F, 32'h104);
        bus_rd(2'd3, rd);
        chk("pass_score", rd, 32'h1);
        bus_wr(2'd1, 32'h200);
        chk("ack_irq", {31'h0, irq}, 32'h0);
        chk("ack_led", {24'h0, led}, 32'hFF);

        // fail round
        bus_wr(2'd1, 32'h104);
        tick(30);
        press(0, 2'd0);
        press(0, 2'd2);
        chk("fail_led", {24'h0, led}, 32'h0F);
        chk("fail_irq", {31'h0, irq}, 32'h1);
        bus_rd(2'd1, rd);
        chk("fail_status", rd, 32'h214);
        bus_rd(2'd3, rd);
        chk("fail_score", rd, 32'h1);

        // abort round, start+ack, locked PATTERN, busy start
        bus_wr(2'd2, 32'd50);
        bus_wr(2'd1, 32'h304);
        chk("startack_irq", {31'h0, irq}, 32'h0);
        chk("startack_led", {24'h0, led}, 32'h81);
        bus_wr(2'd0, 32'hFFFF);
        bus_rd(2'd0, rd);
        chk("pat_locked", rd, 32'hE4);
        tick(52);
        chk("gap_led", {24'h0, led}, 32'h0);
        bus_wr(2'd1, 32'h502);
        bus_rd(2'd1, rd);
        chk("busy_start", rd, 32'h802);
        bus_rd(2'd3, rd);
        chk("busy_clr", rd, 32'h0);
        key[1] = 1'b0;
        wait_led(8'hF0, DB + 6, "abort_led");
        key[1] = 1'b1;
        tick(PRESS_WAIT);
        chk("abort_irq", {31'h0, irq}, 32'h1);
        bus_rd(2'd1, rd);
        chk("abort_status", rd, 32'h404);

        // STEP_TICKS 0 and length 0 both act as 1
        switch[1:0] = 2'd2;
        bus_wr(2'd2, 32'h0);
        bus_wr(2'd1, 32'h100);
        chk("min_on", {24'h0, led}, 32'h81);
        @(negedge clk);
        chk("min_gap", {24'h0, led}, 32'h00);
        @(negedge clk);
        chk("min_input", {24'h0, led}, 32'h04);

        // bouncing key0 never yields a press
        repeat (6) begin
            key[0] = 1'b0;
            tick(4);
            key[0] = 1'b1;
            tick(4);
        end
        tick(PRESS_WAIT);
        bus_rd(2'd1, rd);
        chk("bounce_status", rd, 32'h803);

        // both keys together: abort wins over a mismatching entry
        key = 2'b00;
        wait_led(8'hF0, DB + 6, "both_led");
        key = 2'b11;
        tick(PRESS_WAIT);
        bus_rd(2'd1, rd);
        chk("both_status", rd, 32'h404);

        // reset during INPUT
        bus_wr(2'd1, 32'h100);
        tick(4);
        bus_rd(2'd1, rd);
        chk("pre_rst_status", rd, 32'h803);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_led", {24'h0, led}, 32'h0);
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        bus_rd(2'd1, rd);
        chk("mid_rst_status", rd, 32'h0);
        bus_rd(2'd3, rd);
        chk("mid_rst_score", rd, 32'h0);
        bus_rd(2'd0, rd);
        chk("mid_rst_pat", rd, 32'h0);
        bus_rd(2'd2, rd);
        chk("mid_rst_step", rd, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
